// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 7-segment scanner with blanking, digit masking and PWM brightness
module seg7_scan_mux #(
  parameter int DIGITS       = 8,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIGITS-1:0][6:0] seg_in,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic [DIGITS-1:0]      digit_en,
  input  logic [3:0]             bright,
  output logic [6:0]             seg_out,
  output logic                   dp_out,
  output logic [DIGITS-1:0]      an_out,
  output logic                   frame_tick
);

  localparam int MAXC  = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [3:0]        pwm_cnt, pwm_n;
  logic              wrap;

  // pattern captured at the start of a slot so mid-slot input changes cannot tear the digit
  logic [6:0]        lat_seg, lat_seg_d;
  logic              lat_dp, lat_dp_d;
  logic              lat_en, lat_en_d;

  logic [6:0]        seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] an_d;
  logic              tick_d;

  // state, counters, latched pattern and output registers; reset forces everything dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      lat_seg    <= 7'h7F;
      lat_dp     <= 1'b1;
      lat_en     <= 1'b0;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      pwm_cnt    <= pwm_n;
      lat_seg    <= lat_seg_d;
      lat_dp     <= lat_dp_d;
      lat_en     <= lat_en_d;
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      an_out     <= an_d;
      frame_tick <= tick_d;
    end
  end

  // slot sequencing: blanking gap, then the digit's show window, then advance to the next digit
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = idx;
    pwm_n   = pwm_cnt;
    wrap    = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          state_n = SHOW;
          cnt_n   = '0;
          pwm_n   = '0;
        end
      end
      SHOW: begin
        pwm_n = pwm_cnt + 4'd1;
        if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (idx == IDX_W'(DIGITS - 1)) begin
            idx_n = '0;
            wrap  = 1'b1;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // next output values, derived from the next state so anode and segments always change together
  always_comb begin
    lat_seg_d = lat_seg;
    lat_dp_d  = lat_dp;
    lat_en_d  = lat_en;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    an_d      = '1;
    tick_d    = wrap;
    if (state == BLANK && state_n == SHOW) begin
      lat_seg_d = seg_in[idx];
      lat_dp_d  = dp_in[idx];
      lat_en_d  = digit_en[idx];
    end
    if (state_n == SHOW) begin
      seg_d = lat_seg_d;
      dp_d  = lat_dp_d;
      if (lat_en_d && (pwm_n <= bright)) begin
        an_d = ~(DIGITS'(1) << idx_n);
      end
    end
  end

endmodule
